// File: rtl/mod_n_sequence_checker.sv
// Receive-side monitor for a mod-N count stream: locks onto the legal
// 0..MOD-1 sequence, flags wraps, sequence errors and out-of-range samples.
module mod_n_sequence_checker #(
   parameter int MOD      = 6,
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 2,
   parameter int LOSS_CNT = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             count_valid,
   input  logic             clear_err,
   output logic             locked,
   output logic             wrap_pulse,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             range_err
);

   localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   localparam logic [WIDTH-1:0] MOD_M1   = WIDTH'(MOD - 1);
   localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0] LOSS_V   = RUN_W'(LOSS_CNT);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             have_ref_q, have_ref_d;
   logic [RUN_W-1:0] good_run_q, good_run_d;
   logic [RUN_W-1:0] bad_run_q, bad_run_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             locked_q, locked_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             range_q, range_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic             in_range_s;
   logic             match_s;
   logic [WIDTH-1:0] exp_s;

   // Successor in the legal sequence, evaluated at WIDTH bits.
   function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      if (x == MOD_M1) begin
         r = WIDTH'(0);
      end else begin
         r = x + WIDTH'(1);
      end
      return r;
   endfunction

   assign in_range_s = (count_in <= MOD_M1);
   assign exp_s      = next_val(ref_q);
   assign match_s    = in_range_s && (count_in == exp_s);

   // Next-state computation for the lock FSM, run counters and tally.
   always_comb begin
      state_d     = state_q;
      have_ref_d  = have_ref_q;
      good_run_d  = good_run_q;
      bad_run_d   = bad_run_q;
      ref_d       = ref_q;
      wrap_d      = 1'b0;
      err_d       = 1'b0;
      range_d     = 1'b0;
      err_count_d = err_count_q;

      if (count_valid) begin
         range_d = !in_range_s;
         case (state_q)
            ST_HUNT: begin
               if (!in_range_s) begin
                  have_ref_d = 1'b0;
                  good_run_d = RUN_W'(0);
               end else if (!have_ref_q) begin
                  ref_d      = count_in;
                  have_ref_d = 1'b1;
                  good_run_d = RUN_W'(0);
               end else if (match_s) begin
                  ref_d      = count_in;
                  good_run_d = good_run_q + RUN_W'(1);
                  if ((good_run_q + RUN_W'(1)) == LOCK_V) begin
                     state_d   = ST_LOCKED;
                     bad_run_d = RUN_W'(0);
                  end else begin
                     state_d   = ST_HUNT;
                  end
               end else begin
                  ref_d      = count_in;
                  good_run_d = RUN_W'(0);
               end
            end
            ST_LOCKED: begin
               if (match_s) begin
                  ref_d     = count_in;
                  bad_run_d = RUN_W'(0);
                  wrap_d    = (ref_q == MOD_M1) && (count_in == WIDTH'(0));
               end else begin
                  // Expectation free-runs so one glitch does not force a resync.
                  err_d     = 1'b1;
                  ref_d     = exp_s;
                  bad_run_d = bad_run_q + RUN_W'(1);
                  if ((bad_run_q + RUN_W'(1)) == LOSS_V) begin
                     state_d    = ST_HUNT;
                     ref_d      = count_in;
                     good_run_d = RUN_W'(0);
                     have_ref_d = in_range_s;
                  end else begin
                     state_d    = ST_LOCKED;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end else begin
         range_d = 1'b0;
      end

      if (clear_err) begin
         err_count_d = ERR_W'(0);
      end else if (err_d && (err_count_q != ERR_MAX)) begin
         err_count_d = err_count_q + ERR_W'(1);
      end else begin
         err_count_d = err_count_q;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_HUNT;
         have_ref_q  <= 1'b0;
         good_run_q  <= RUN_W'(0);
         bad_run_q   <= RUN_W'(0);
         ref_q       <= WIDTH'(0);
         locked_q    <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
         range_q     <= 1'b0;
         err_count_q <= ERR_W'(0);
      end else begin
         state_q     <= state_d;
         have_ref_q  <= have_ref_d;
         good_run_q  <= good_run_d;
         bad_run_q   <= bad_run_d;
         ref_q       <= ref_d;
         locked_q    <= locked_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
         range_q     <= range_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked     = locked_q;
   assign wrap_pulse = wrap_q;
   assign err_pulse  = err_q;
   assign range_err  = range_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_mod_n_sequence_checker.sv
// Directed self-checking bench for mod_n_sequence_checker (MOD=6 defaults).
module tb_mod_n_sequence_checker;

   logic       clk;
   logic       reset;
   logic [2:0] count_in;
   logic       count_valid;
   logic       clear_err;
   logic       locked;
   logic       wrap_pulse;
   logic       err_pulse;
   logic [7:0] err_count;
   logic       range_err;

   int n_checks;
   int n_fails;

   mod_n_sequence_checker dut (
      .clk         (clk),
      .reset       (reset),
      .count_in    (count_in),
      .count_valid (count_valid),
      .clear_err   (clear_err),
      .locked      (locked),
      .wrap_pulse  (wrap_pulse),
      .err_pulse   (err_pulse),
      .err_count   (err_count),
      .range_err   (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one sample, clock it, and settle just after the edge.
   task automatic step(input logic [2:0] c, input logic v, input logic clr);
      count_in    = c;
      count_valid = v;
      clear_err   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic l, input logic w,
                            input logic e, input logic [7:0] cnt, input logic r);
      check_eq({tag, ".locked"}, 32'(locked), 32'(l));
      check_eq({tag, ".wrap"},   32'(wrap_pulse), 32'(w));
      check_eq({tag, ".err"},    32'(err_pulse), 32'(e));
      check_eq({tag, ".cnt"},    32'(err_count), 32'(cnt));
      check_eq({tag, ".range"},  32'(range_err), 32'(r));
   endtask

   initial begin
      logic [2:0] g;
      n_checks    = 0;
      n_fails     = 0;
      reset       = 1'b1;
      count_in    = 3'd3;
      count_valid = 1'b1;
      clear_err   = 1'b0;

      // 1: reset with live input, then lock on 0,1,2
      for (int i = 0; i < 3; i++) begin
         step(3'd3, 1'b1, 1'b0);
         check_all("rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      end
      reset = 1'b0;
      step(3'd0, 1'b1, 1'b0); check_all("t1_s0", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd1, 1'b1, 1'b0); check_all("t1_s1", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd2, 1'b1, 1'b0); check_all("t1_s2", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      // 2: single wrap on 5->0
      step(3'd3, 1'b1, 1'b0); check_all("t2_s3", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd4, 1'b1, 1'b0); check_all("t2_s4", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd5, 1'b1, 1'b0); check_all("t2_s5", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd0, 1'b1, 1'b0); check_all("t2_s0", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
      step(3'd1, 1'b1, 1'b0); check_all("t2_s1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      // 3: bring ref to 3, one glitch, free-running expectation still wraps
      step(3'd2, 1'b1, 1'b0);
      step(3'd3, 1'b1, 1'b0); check_all("t3_ref3", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd2, 1'b1, 1'b0); check_all("t3_glitch", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
      step(3'd5, 1'b1, 1'b0); check_all("t3_s5", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);
      step(3'd0, 1'b1, 1'b0); check_all("t3_s0", 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);

      // idle cycle with clear: pulses low, state held, tally cleared
      step(3'd4, 1'b0, 1'b1); check_all("idle_clr", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      // 4: ref=1, two mismatches lose lock; reference restarts from the last sample (4)
      step(3'd1, 1'b1, 1'b0); check_all("t4_ref1", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd4, 1'b1, 1'b0); check_all("t4_mm1", 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
      step(3'd4, 1'b1, 1'b0); check_all("t4_mm2", 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
      step(3'd5, 1'b1, 1'b0); check_all("t4_s5", 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      step(3'd0, 1'b1, 1'b0); check_all("t4_s0", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0);
      step(3'd1, 1'b1, 1'b0); check_all("t4_s1", 1'b1, 1'b0, 1'b0, 8'd2, 1'b0);

      // 5: reset mid-run, out-of-range in HUNT, then in LOCKED
      reset = 1'b1;
      step(3'd1, 1'b1, 1'b0); check_all("t5_rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      reset = 1'b0;
      step(3'd7, 1'b1, 1'b0); check_all("t5_hunt7", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      step(3'd0, 1'b1, 1'b0); check_all("t5_s0", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd1, 1'b1, 1'b0); check_all("t5_s1", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd2, 1'b1, 1'b0); check_all("t5_s2", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      step(3'd6, 1'b1, 1'b0); check_all("t5_lock6", 1'b1, 1'b0, 1'b1, 8'd1, 1'b1);
      step(3'd4, 1'b1, 1'b0); check_all("t5_s4", 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);

      // 6: each glitch/recover pair adds one error while staying locked (ref=4)
      g = 3'd0;
      for (int i = 0; i < 254; i++) begin
         step(g, 1'b1, 1'b0);
         step(g, 1'b1, 1'b0);
         g = (g >= 3'd4) ? g - 3'd4 : g + 3'd2;
      end
      check_all("t6_at255", 1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
      step(g, 1'b1, 1'b0); check_all("t6_sat", 1'b1, 1'b0, 1'b1, 8'd255, 1'b0);
      step(g, 1'b1, 1'b0); check_all("t6_recov", 1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
      g = (g >= 3'd4) ? g - 3'd4 : g + 3'd2;
      step(g, 1'b1, 1'b1); check_all("t6_clr_err", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
